// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator for the single-cycle core.
// Selects the next PC from four modes: sequential, PC-relative branch,
// register-indirect jump and predicted return. The predicted return comes
// from a circular return-address stack. The unit holds on stall and
// redirects to TRAP_PC when a target is not word aligned.
module pc_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0]   TRAP_PC   = WIDTH'(32'h0000_0100),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pcsrc,
    input  logic [WIDTH-1:0] immop,
    input  logic [WIDTH-1:0] rs1,
    input  logic             call,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misalign
);

    localparam int             PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [WIDTH-1:0] FOUR_W = WIDTH'(4);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [PW:0]    CNT_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]    CNT_MAX  = (PW+1)'(RAS_DEPTH);
    localparam logic [PW-1:0]  PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]    top_r;
    logic [PW:0]      cnt_r;
    logic             misalign_r;
    logic             empty_r;
    logic             full_r;

    logic [WIDTH-1:0] link_s;
    logic [WIDTH-1:0] jalr_s;
    logic [WIDTH-1:0] tgt_s;
    logic [WIDTH-1:0] pc_n_s;
    logic             trap_s;
    logic             pop_s;
    logic [PW-1:0]    top_n_s;
    logic [PW:0]      cnt_n_s;
    logic             wr_en_s;
    logic [PW-1:0]    wr_idx_s;

    assign link_s    = pc_r + FOUR_W;
    assign pc        = pc_r;
    assign pc_plus4  = link_s;
    assign ras_empty = empty_r;
    assign ras_full  = full_r;
    assign misalign  = misalign_r;

    // Candidate target selection and alignment check
    always_comb begin
        jalr_s = (rs1 + immop) & ~ONE_W;
        pop_s  = (pcsrc == 2'b11) && (cnt_r != CNT_ZERO);
        tgt_s  = link_s;
        case (pcsrc)
            2'b00: tgt_s = link_s;
            2'b01: tgt_s = pc_r + immop;
            2'b10: tgt_s = jalr_s;
            2'b11: begin
                // An empty stack falls back to the register-indirect target
                if (pop_s) begin
                    tgt_s = ras_mem_r[top_r];
                end else begin
                    tgt_s = jalr_s;
                end
            end
            default: tgt_s = link_s;
        endcase
        trap_s = tgt_s[1];
        if (trap_s) begin
            pc_n_s = TRAP_PC;
        end else begin
            pc_n_s = tgt_s;
        end
    end

    // Return-stack pointer/count update and write selection
    always_comb begin
        top_n_s  = top_r;
        cnt_n_s  = cnt_r;
        wr_en_s  = 1'b0;
        wr_idx_s = top_r;
        if (pop_s && call) begin
            // Pop then push: the top entry is simply replaced
            wr_en_s  = 1'b1;
            wr_idx_s = top_r;
        end else if (pop_s) begin
            top_n_s = top_r - PTR_ONE;
            cnt_n_s = cnt_r - CNT_ONE;
        end else if (call) begin
            // A full stack overwrites its oldest entry; the pointer wraps
            wr_en_s  = 1'b1;
            wr_idx_s = top_r + PTR_ONE;
            top_n_s  = top_r + PTR_ONE;
            if (cnt_r == CNT_MAX) begin
                cnt_n_s = cnt_r;
            end else begin
                cnt_n_s = cnt_r + CNT_ONE;
            end
        end else begin
            top_n_s = top_r;
        end
    end

    // PC, stack pointer/count, status flags and trap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            top_r      <= PTR_ZERO;
            cnt_r      <= CNT_ZERO;
            misalign_r <= 1'b0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
        end else if (stall) begin
            misalign_r <= 1'b0;
        end else begin
            pc_r       <= pc_n_s;
            top_r      <= top_n_s;
            cnt_r      <= cnt_n_s;
            misalign_r <= trap_s;
            empty_r    <= (cnt_n_s == CNT_ZERO);
            full_r     <= (cnt_n_s == CNT_MAX);
        end
    end

    // Return-stack storage; contents survive reset, only pointer/count clear
    always_ff @(posedge clk) begin
        if (!rst && !stall && wr_en_s) begin
            ras_mem_r[wr_idx_s] <= link_s;
        end
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised successor to the single-step program-counter register. It generates the fetch address for the single-cycle core and adds the features the CPU now needs: stall hold, four next-PC modes (sequential, PC-relative branch, register-indirect jump, predicted return), a circular return-address stack (RAS) and misaligned-target trapping. It sits between the control unit/ALU and instruction memory, and its `pc` output drives the instruction-memory address directly.

## Interface
Parameters:
- `WIDTH`, 32: address width in bits, minimum 8.
- `RESET_PC`, 0: value loaded into `pc` on reset. Must be 4-byte aligned.
- `TRAP_PC`, 32'h0000_0100: redirect address used on a misaligned target. Must be 4-byte aligned.
- `RAS_DEPTH`, 4: number of RAS entries. Power of two, at least 2.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high; dominates every other input.
- `stall`, input, 1: freeze the PC and the RAS this cycle.
- `pcsrc`, input, 2: next-PC select. 00 = seq, 01 = branch, 10 = jalr, 11 = ret.
- `immop`, input, WIDTH: sign-extended immediate.
- `rs1`, input, WIDTH: register operand used by the jalr mode.
- `call`, input, 1: push the link address (`pc`+4) onto the RAS.
- `pc`, output, WIDTH: current fetch address (registered).
- `pc_plus4`, output, WIDTH: `pc`+4, combinational.
- `ras_empty`, output, 1: RAS count is 0 (registered state).
- `ras_full`, output, 1: RAS count equals RAS_DEPTH (registered state).
- `misalign`, output, 1: one-cycle registered pulse marking that a trap was taken.

## Operation
Candidate target (`tgt`) by mode, all sums modulo 2^WIDTH with wrap-around and no carry out:
- 00 (seq): `pc`+4.
- 01 (branch): `pc`+`immop`.
- 10 (jalr): (`rs1`+`immop`) with bit 0 forced to 0.
- 11 (ret):
  - RAS not empty: `tgt` is the top entry.
  - RAS empty: `tgt` is the jalr target and the count stays 0.

Misalign check:
- If `tgt`[1] is 1, the next `pc` is TRAP_PC and `misalign` is 1 in the following cycle.
- If `tgt`[1] is 0, the next `pc` is `tgt`.
- `tgt`[0] is never checked. In modes 00, 01 and 11 it cannot be set from aligned inputs, and the jalr mode clears it.

RAS:
- Circular buffer with a top pointer and a count that saturates at RAS_DEPTH.
- Push (`call`=1): write `pc`+4 at top+1, then advance top.
- Push when full: overwrites the oldest entry. The count stays at RAS_DEPTH and the pointer wraps modulo RAS_DEPTH.
- Pop (mode 11 with count > 0): read the top entry, then decrement top and count.
- `call`=1 with mode 11 on the same edge (pop then push): the top entry is replaced by `pc`+4. The count and pointer do not change. If the RAS was empty, this is a plain push.
- The RAS is updated even when a trap is taken. The trap does not cancel the push or pop.
- RAS contents are not cleared on reset. Only the pointer and count reset.

Stall:
- When `stall` is 1, `pc`, the RAS and its count all hold, and `misalign` is 0 next cycle.
- `pcsrc` and `call` are ignored while `stall` is 1.

## Timing
- Reset values, taking effect at the first rising edge with `rst`=1: `pc`=RESET_PC, RAS count=0, top pointer=0, `ras_empty`=1, `ras_full`=0, `misalign`=0.
- Reset in the middle of a push/pop or during a stall: reset wins and no RAS write occurs on that edge.
- Latency: the new `pc` appears one cycle after `pcsrc`, `immop`, `rs1` and `call` are sampled.
- `pc_plus4` follows `pc` combinationally with zero cycles of delay.
- `ras_empty` and `ras_full` reflect the post-edge count in the same cycle as the new `pc`.
- `misalign` is high for exactly one cycle per trap.
- On back-to-back traps, `misalign` stays high for each consecutive cycle.
- No combinational path from any input to `pc`, `ras_*` or `misalign`.
- Single clock domain; one operation per cycle; no handshake beyond `stall`.

## Test plan
- Reset then seq: `rst`=1 for 2 cycles, then `pcsrc`=00 for 3 cycles -> `pc` = 0, 4, 8, 12 and `ras_empty`=1. Assert `stall`=1 for 2 cycles -> `pc` holds at 12.
- Branch and wrap: `pc`=0x10, `pcsrc`=01, `immop`=0xFFFF_FFF0 -> `pc`=0. Then `pc`=0xFFFF_FFFC with `pcsrc`=00 -> `pc`=0.
- jalr and trap:
  - `rs1`=0x203, `immop`=1, `pcsrc`=10 -> `pc`=0x204, `misalign`=0.
  - `rs1`=0x202, `immop`=0 -> `pc`=0x100, `misalign`=1 for one cycle.
- Call/return nesting (RAS_DEPTH=4):
  - Calls at `pc`=0x20, 0x80 and 0xC0 -> pushes 0x24, 0x84, 0xC4.
  - Three returns -> `pc`=0xC4, then 0x84, then 0x24, with `ras_empty`=1 after the third.
  - A fourth return with `rs1`=0x300, `immop`=0 -> `pc`=0x300.
- Overflow: 6 calls pushing 0x04, 0x08, 0x0C, 0x10, 0x14, 0x18 -> `ras_full`=1. Four returns then yield 0x18, 0x14, 0x10, 0x0C.
- Simultaneous and reset:
  - At `pc`=0x40, top entry 0x84: `pcsrc`=11 with `call`=1 -> `pc`=0x84, the top becomes 0x44 and the count is unchanged.
  - Asserting `rst` during a call -> `pc`=RESET_PC and `ras_empty`=1.
